ft_pipe_ctrl: RTL and testbench

FT_PIPE_CTRL -- requirements
Module: ft_pipe_ctrl

---
 rtl/ft_pipe_ctrl.sv | 128 ++++++++++++
 tb/tb_ft_pipe_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ft_pipe_ctrl.sv
// Pipeline stall/flush controller with a fence sequencer.
// A fence drains the pipe for DRAIN_CYCLES unstalled cycles, then flushes.
module ft_pipe_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       cpurst,
    input  logic       de_stall,
    input  logic       exe_stall,
    input  logic       memacc_stall,
    input  logic       fet_flush_req,
    input  logic       branch_predict_err,
    input  logic       mem2wb_exp_ffout,
    input  logic       fence_req,
    output logic       stall,
    output logic       fet_flush,
    output logic       fence_stall,
    output logic       pc_hold,
    output logic       fence_done,
    output logic       flush_pend,
    output logic [7:0] flush_cnt
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned FC_W  = 8;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [FC_W-1:0]  FC_MAX     = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0] w_drain_nxt;
    logic             r_flush_pend;
    logic [FC_W-1:0]  r_flush_cnt;
    logic             w_flush_src;
    logic             w_fsm_flush;

    assign stall       = de_stall | exe_stall | memacc_stall;
    assign w_flush_src = fet_flush_req | branch_predict_err | mem2wb_exp_ffout;
    // Any number of pending/coincident requests collapse into one strobe.
    assign fet_flush   = (w_flush_src | r_flush_pend | w_fsm_flush) & ~stall;
    assign flush_pend  = r_flush_pend;
    assign flush_cnt   = r_flush_cnt;

    // Fence state register
    always_ff @(posedge clk) begin
        if (cpurst) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    // Fence next-state and decoded outputs; a writeback exception aborts the fence
    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        w_fsm_flush = 1'b0;
        fence_stall = 1'b0;
        pc_hold     = 1'b0;
        fence_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (fence_req) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = '0;
                end
            end
            ST_DRAIN: begin
                fence_stall = 1'b1;
                pc_hold     = 1'b1;
                if (mem2wb_exp_ffout) begin
                    w_state_nxt = ST_IDLE;
                end else if (!stall) begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_drain_nxt = r_drain_cnt + CNT_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                w_fsm_flush = 1'b1;
                fence_stall = 1'b1;
                pc_hold     = 1'b1;
                if (mem2wb_exp_ffout) begin
                    w_state_nxt = ST_IDLE;
                end else if (fet_flush) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                fence_done  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pending-flush latch and saturating strobe counter
    always_ff @(posedge clk) begin
        if (cpurst) begin
            r_flush_pend <= 1'b0;
            r_flush_cnt  <= '0;
        end else begin
            if (fet_flush) begin
                r_flush_pend <= 1'b0;
            end else if (w_flush_src && stall) begin
                r_flush_pend <= 1'b1;
            end
            if (fet_flush && (r_flush_cnt != FC_MAX)) begin
                r_flush_cnt <= r_flush_cnt + FC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ft_pipe_ctrl.sv
// Directed self-checking bench for ft_pipe_ctrl (DRAIN_CYCLES = 3).
module tb_ft_pipe_ctrl;

    logic       clk;
    logic       cpurst;
    logic       de_stall;
    logic       exe_stall;
    logic       memacc_stall;
    logic       fet_flush_req;
    logic       branch_predict_err;
    logic       mem2wb_exp_ffout;
    logic       fence_req;
    logic       stall;
    logic       fet_flush;
    logic       fence_stall;
    logic       pc_hold;
    logic       fence_done;
    logic       flush_pend;
    logic [7:0] flush_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    ft_pipe_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk                (clk),
        .cpurst             (cpurst),
        .de_stall           (de_stall),
        .exe_stall          (exe_stall),
        .memacc_stall       (memacc_stall),
        .fet_flush_req      (fet_flush_req),
        .branch_predict_err (branch_predict_err),
        .mem2wb_exp_ffout   (mem2wb_exp_ffout),
        .fence_req          (fence_req),
        .stall              (stall),
        .fet_flush          (fet_flush),
        .fence_stall        (fence_stall),
        .pc_hold            (pc_hold),
        .fence_done         (fence_done),
        .flush_pend         (flush_pend),
        .flush_cnt          (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cpurst = 1'b1;
        de_stall = 1'b0; exe_stall = 1'b0; memacc_stall = 1'b0;
        fet_flush_req = 1'b0; branch_predict_err = 1'b0;
        mem2wb_exp_ffout = 1'b0; fence_req = 1'b0;
        tick(); tick();
        cpurst = 1'b0;
        #1;
        chk("rst_fence_stall", 8'(fence_stall), 8'd0);
        chk("rst_pc_hold",     8'(pc_hold),     8'd0);
        chk("rst_fence_done",  8'(fence_done),  8'd0);
        chk("rst_fet_flush",   8'(fet_flush),   8'd0);
        chk("rst_flush_pend",  8'(flush_pend),  8'd0);
        chk("rst_flush_cnt",   flush_cnt,       8'd0);

        // Stall OR of each source
        de_stall = 1'b1; #1; chk("stall_de", 8'(stall), 8'd1); de_stall = 1'b0;
        exe_stall = 1'b1; #1; chk("stall_exe", 8'(stall), 8'd1); exe_stall = 1'b0;
        memacc_stall = 1'b1; #1; chk("stall_mem", 8'(stall), 8'd1); memacc_stall = 1'b0;
        #1; chk("stall_none", 8'(stall), 8'd0);

        // Unstalled flush: same-cycle strobe
        tick();
        branch_predict_err = 1'b1; #1;
        chk("nostall_flush", 8'(fet_flush), 8'd1);
        chk("nostall_cnt0", flush_cnt, 8'd0);
        tick();
        branch_predict_err = 1'b0; #1;
        chk("nostall_cnt1", flush_cnt, 8'd1);
        chk("nostall_flush_off", 8'(fet_flush), 8'd0);

        // Flush under stall: two events, one strobe at cycle 5
        tick();
        exe_stall = 1'b1; #1;
        chk("st_c0_pend", 8'(flush_pend), 8'd0);
        tick();
        fet_flush_req = 1'b1; #1;
        chk("st_c1_flush", 8'(fet_flush), 8'd0);
        chk("st_c1_pend", 8'(flush_pend), 8'd0);
        tick();
        fet_flush_req = 1'b0; #1;
        chk("st_c2_pend", 8'(flush_pend), 8'd1);
        tick();
        branch_predict_err = 1'b1; #1;
        chk("st_c3_pend", 8'(flush_pend), 8'd1);
        chk("st_c3_flush", 8'(fet_flush), 8'd0);
        tick();
        branch_predict_err = 1'b0; #1;
        chk("st_c4_pend", 8'(flush_pend), 8'd1);
        tick();
        exe_stall = 1'b0; #1;
        chk("st_c5_pend", 8'(flush_pend), 8'd1);
        chk("st_c5_flush", 8'(fet_flush), 8'd1);
        tick(); #1;
        chk("st_c6_pend", 8'(flush_pend), 8'd0);
        chk("st_c6_flush", 8'(fet_flush), 8'd0);
        chk("st_c6_cnt", flush_cnt, 8'd2);

        // Fence with no stall
        fence_req = 1'b1; #1;
        chk("f_c0_fstall", 8'(fence_stall), 8'd0);
        tick();
        fence_req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk("f_fstall", 8'(fence_stall), 8'd1);
            chk("f_pchold", 8'(pc_hold), 8'd1);
            chk("f_flush", 8'(fet_flush), (c == 4) ? 8'd1 : 8'd0);
            chk("f_done_early", 8'(fence_done), 8'd0);
            tick();
        end
        #1;
        chk("f_c5_done", 8'(fence_done), 8'd1);
        chk("f_c5_pchold", 8'(pc_hold), 8'd0);
        chk("f_c5_fstall", 8'(fence_stall), 8'd0);
        chk("f_c5_cnt", flush_cnt, 8'd3);
        tick(); #1;
        chk("f_c6_done", 8'(fence_done), 8'd0);

        // Fence with memacc_stall in cycles 2-3
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            memacc_stall = (c == 2 || c == 3);
            #1;
            chk("fs_fstall", 8'(fence_stall), 8'd1);
            chk("fs_flush", 8'(fet_flush), (c == 6) ? 8'd1 : 8'd0);
            chk("fs_done_early", 8'(fence_done), 8'd0);
            tick();
        end
        memacc_stall = 1'b0; #1;
        chk("fs_c7_done", 8'(fence_done), 8'd1);
        chk("fs_c7_cnt", flush_cnt, 8'd4);
        tick();

        // Exception aborts fence during DRAIN
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0; #1;
        chk("ex_c1_fstall", 8'(fence_stall), 8'd1);
        tick();
        mem2wb_exp_ffout = 1'b1; #1;
        chk("ex_c2_flush", 8'(fet_flush), 8'd1);
        tick();
        mem2wb_exp_ffout = 1'b0; #1;
        chk("ex_c3_fstall", 8'(fence_stall), 8'd0);
        chk("ex_c3_done", 8'(fence_done), 8'd0);
        chk("ex_c3_cnt", flush_cnt, 8'd5);
        tick(); #1;
        chk("ex_c4_done", 8'(fence_done), 8'd0);
        chk("ex_c4_pchold", 8'(pc_hold), 8'd0);

        // Branch flush coincident with FLUSH-state strobe: single count
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0;
        tick(); tick(); tick();
        branch_predict_err = 1'b1; #1;
        chk("co_c4_flush", 8'(fet_flush), 8'd1);
        chk("co_c4_fstall", 8'(fence_stall), 8'd1);
        tick();
        branch_predict_err = 1'b0; #1;
        chk("co_c5_done", 8'(fence_done), 8'd1);
        chk("co_c5_cnt", flush_cnt, 8'd6);
        tick();

        // Saturation over 300 strobes
        fet_flush_req = 1'b1;
        repeat (300) tick();
        fet_flush_req = 1'b0; #1;
        chk("sat_cnt", flush_cnt, 8'd255);

        // Reset mid-fence discards it; stall still follows inputs
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0;
        tick(); #1;
        chk("rm_fstall", 8'(fence_stall), 8'd1);
        cpurst = 1'b1;
        de_stall = 1'b1; #1;
        chk("rm_stall_in_rst", 8'(stall), 8'd1);
        tick();
        cpurst = 1'b0;
        de_stall = 1'b0; #1;
        chk("rm_cnt", flush_cnt, 8'd0);
        chk("rm_fstall_off", 8'(fence_stall), 8'd0);
        chk("rm_pchold_off", 8'(pc_hold), 8'd0);
        chk("rm_flush_off", 8'(fet_flush), 8'd0);
        for (int c = 0; c < 6; c++) begin
            chk("rm_no_done", 8'(fence_done), 8'd0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
